// File: rtl/accumulator_ctrl_pkg.sv
// Shared constants and state type for the accumulator controller and its RAM.
package accumulator_ctrl_pkg;

   localparam int ACC_DATA_WIDTH = 32;
   localparam int ACC_ARRAY_SIZE = 16;
   localparam int ACC_ADDR_WIDTH = $clog2(ACC_ARRAY_SIZE);
   localparam int ACC_PASS_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DRAIN = 2'd2
   } acc_state_t;

endpackage

// File: rtl/accumulator_ctrl_if.sv
// Streaming handshakes: partial sums in from the array, accumulated words out.
interface accumulator_ctrl_if
   import accumulator_ctrl_pkg::*;
   #(parameter int DATA_WIDTH = ACC_DATA_WIDTH);

   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_last;

   // Upstream producer / downstream consumer side
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   // Controller side
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );

endinterface

// File: rtl/accumulator_ctrl_addr_counter.sv
// Wrapping address counter shared by the accumulate and drain phases.
module accumulator_ctrl_addr_counter
   import accumulator_ctrl_pkg::*;
   #(
      parameter int ARRAY_SIZE = ACC_ARRAY_SIZE,
      parameter int ADDR_WIDTH = $clog2(ARRAY_SIZE)
   )
   (
      input  logic                  clk,
      input  logic                  rst,
      input  logic                  i_inc,
      input  logic                  i_clear,
      output logic [ADDR_WIDTH-1:0] o_count,
      output logic                  o_terminal
   );

   localparam logic [ADDR_WIDTH-1:0] LP_LAST = ADDR_WIDTH'(ARRAY_SIZE - 1);

   logic [ADDR_WIDTH-1:0] r_count;

   // Clear wins over increment; the last address rolls back to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_inc) begin
         r_count <= (r_count == LP_LAST) ? '0 : r_count + 1'b1;
      end
   end

   assign o_count    = r_count;
   assign o_terminal = (r_count == LP_LAST);

endmodule

// File: rtl/accumulator_ram.sv
// Accumulator RAM: one synchronous write port, one asynchronous read port.
module accumulator_ram
   import accumulator_ctrl_pkg::*;
   #(
      parameter int DATA_WIDTH = ACC_DATA_WIDTH,
      parameter int ARRAY_SIZE = ACC_ARRAY_SIZE,
      parameter int ADDR_WIDTH = $clog2(ARRAY_SIZE)
   )
   (
      input  logic                  clk,
      input  logic                  i_wr_en,
      input  logic [ADDR_WIDTH-1:0] i_wr_addr,
      input  logic [DATA_WIDTH-1:0] i_din,
      input  logic [ADDR_WIDTH-1:0] i_rd_addr,
      output logic [DATA_WIDTH-1:0] o_dout
   );

   logic [DATA_WIDTH-1:0] r_mem [ARRAY_SIZE];

   // Storage is deliberately not reset; pass 0 of every job overwrites it.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_din;
      end
   end

   assign o_dout = r_mem[i_rd_addr];

endmodule

// File: rtl/accumulator_ctrl.sv
// Read-modify-write accumulation over K passes, then drain of the vector.
//
// state    | meaning
// ST_IDLE  | waiting for start; K==0 just pulses done
// ST_ACCUM | accepting partial sums, one RMW per handshake
// ST_DRAIN | streaming RAM contents out, address 0 first
module accumulator_ctrl
   import accumulator_ctrl_pkg::*;
   #(
      parameter int DATA_WIDTH = ACC_DATA_WIDTH,
      parameter int ARRAY_SIZE = ACC_ARRAY_SIZE,
      parameter int ADDR_WIDTH = $clog2(ARRAY_SIZE)
   )
   (
      input  logic                      clk,
      input  logic                      rst,
      input  logic                      i_start,
      input  logic [ACC_PASS_WIDTH-1:0] i_num_passes,
      accumulator_ctrl_if.slave         bus,
      output logic                      o_busy,
      output logic                      o_done,
      output logic                      o_ram_wr_en,
      output logic [ADDR_WIDTH-1:0]     o_ram_wr_addr,
      output logic [DATA_WIDTH-1:0]     o_ram_din,
      output logic [ADDR_WIDTH-1:0]     o_ram_rd_addr,
      input  logic [DATA_WIDTH-1:0]     i_ram_dout
   );

   acc_state_t                r_state;
   logic [ACC_PASS_WIDTH-1:0] r_pass;
   logic [ACC_PASS_WIDTH-1:0] r_k;
   logic                      r_in_ready;
   logic                      r_out_valid;
   logic                      r_busy;
   logic                      r_done;

   logic [ADDR_WIDTH-1:0]     w_addr;
   logic                      w_addr_term;
   logic                      w_in_hs;
   logic                      w_out_hs;
   logic                      w_start_job;
   logic                      w_last_pass;

   // in_ready/out_valid are only ever set in their own state, so they double
   // as state qualifiers for the handshakes.
   assign w_in_hs     = r_in_ready & bus.in_valid;
   assign w_out_hs    = r_out_valid & bus.out_ready;
   assign w_start_job = (r_state == ST_IDLE) & i_start & (i_num_passes != '0);
   assign w_last_pass = (r_pass == r_k - 1'b1);

   accumulator_ctrl_addr_counter #(
      .ARRAY_SIZE (ARRAY_SIZE),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_addr (
      .clk        (clk),
      .rst        (rst),
      .i_inc      (w_in_hs | w_out_hs),
      .i_clear    (w_start_job),
      .o_count    (w_addr),
      .o_terminal (w_addr_term)
   );

   // Sequencer: state, pass count, latched K and registered status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_pass      <= '0;
         r_k         <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  if (i_num_passes == '0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_k        <= i_num_passes;
                     r_pass     <= '0;
                     r_in_ready <= 1'b1;
                     r_busy     <= 1'b1;
                     r_state    <= ST_ACCUM;
                  end
               end
            end
            ST_ACCUM: begin
               if (w_in_hs && w_addr_term) begin
                  if (w_last_pass) begin
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_state     <= ST_DRAIN;
                  end else begin
                     r_pass <= r_pass + 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               if (w_out_hs && w_addr_term) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_done      <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_in_ready  <= 1'b0;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   // Pass 0 overwrites so stale RAM contents never enter a sum.
   assign o_ram_din     = (r_pass == '0) ? bus.in_data : (i_ram_dout + bus.in_data);
   assign o_ram_wr_en   = w_in_hs;
   assign o_ram_wr_addr = w_addr;
   assign o_ram_rd_addr = w_addr;

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = i_ram_dout;
   assign bus.out_last  = r_out_valid & w_addr_term;

   assign o_busy = r_busy;
   assign o_done = r_done;

endmodule

// File: doc/accumulator_ctrl.md
Name: accumulator_ctrl

Overview:
Controller on the far side of Accumulator_RAM: it owns the RAM's write port and its asynchronous read port. It accepts a stream of partial-sum words from the systolic array and performs read-modify-write accumulation over a programmable number of passes. It then drains the accumulated vector to a downstream consumer over a valid/ready interface.

Parameters:
DATA_WIDTH, 32, width of partial sums, RAM words and output data
ARRAY_SIZE, 16, RAM depth and number of words per pass
ADDR_WIDTH, $clog2(ARRAY_SIZE), RAM address width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse that begins a job; sampled only in IDLE
num_passes  in  8  number of passes K, sampled together with start
in_valid  in  1  partial-sum word valid
in_ready  out  1  controller accepts a word
in_data  in  DATA_WIDTH  partial-sum word
out_valid  out  1  drained word valid
out_ready  in  1  downstream accepts the word
out_data  out  DATA_WIDTH  accumulated word
out_last  out  1  marks the word at address ARRAY_SIZE-1
busy  out  1  high in ACCUM and DRAIN
done  out  1  one-cycle pulse at job end
ram_wr_en  out  1  to RAM wr_en
ram_wr_addr  out  ADDR_WIDTH  to RAM wr_addr
ram_din  out  DATA_WIDTH  to RAM din
ram_rd_addr  out  ADDR_WIDTH  to RAM rd_addr
ram_dout  in  DATA_WIDTH  from RAM dout, combinational read

Behaviour:
- State machine: IDLE, ACCUM, DRAIN. Registers: addr counter (ADDR_WIDTH), pass counter (8 bit), latched K.
- Reset values: state IDLE, all counters 0, in_ready 0, out_valid 0, out_last 0, busy 0, done 0, ram_wr_en 0. All outputs take their reset values immediately on rst, with no clock required. RAM contents are not touched by reset.
- IDLE:
  - start with K>=1: latch K, clear counters, go to ACCUM.
  - start with K==0: no transition, no RAM write, done pulses the next cycle.
  - start while busy is ignored.
- ACCUM:
  - in_ready=1.
  - ram_rd_addr = ram_wr_addr = addr counter.
  - ram_wr_en = in_valid & in_ready, combinational.
  - ram_din = in_data when pass counter==0 (overwrite, which discards stale contents); otherwise ram_dout + in_data.
  - Addition is modulo 2^DATA_WIDTH; carry is dropped, no saturation.
  - Each handshake increments addr. At ARRAY_SIZE-1, addr wraps to 0 and the pass counter increments.
  - The handshake at pass K-1, addr ARRAY_SIZE-1 moves to DRAIN on the next edge. There are no writes after it.
  - Throughput: 1 word/cycle. Cycles with in_valid=0 cause no counter change and no write.
- DRAIN:
  - in_ready=0, ram_wr_en=0.
  - ram_rd_addr = addr counter (0 on entry).
  - out_data = ram_dout, combinational through the RAM's async read.
  - out_valid=1 from the first cycle in DRAIN.
  - out_last = (addr==ARRAY_SIZE-1).
  - Each out_valid&out_ready handshake increments addr. out_data stays stable while out_ready=0.
  - The handshake with out_last moves to IDLE, and done pulses in the first IDLE cycle.
- Reset mid-ACCUM or mid-DRAIN abandons the job. The next job's pass 0 overwrites every address, so stale data never leaks.
- The same address never has a write and a drain read in the same cycle.

Decomposition:
- Shared package/header acc_pkg: state encodings (IDLE/ACCUM/DRAIN localparams) and the DATA_WIDTH/ARRAY_SIZE defaults shared with Accumulator_RAM.
- One sub-module, acc_addr_counter: an ADDR_WIDTH wrapping counter with inc and clear inputs and a terminal flag. It is reused for ACCUM and DRAIN addressing, with the pass counter driven by its terminal flag.
- Bench instantiates accumulator_ctrl together with the real Accumulator_RAM.

Test Plan:
1. K=1, in_data=i+0xCAFE0000 for i=0..15, out_ready=1 -> drain yields 0xCAFE0000..0xCAFE000F in order; out_last only on the 16th word; done pulses once, 1 cycle after the last handshake.
2. K=3, every pass word i = i+1 -> drain yields 3*(i+1), i.e. 0x3,0x6,...,0x30; exactly 48 ram_wr_en cycles.
3. K=2, all words 0xFFFFFFFF then all 0x00000002 -> every drained word is 0x00000001 (wrap).
4. K=2 with in_valid low on alternate cycles, out_ready toggling every cycle -> no word dropped or duplicated; ram_wr_en high only on input handshakes; out_data constant while stalled.
5. rst pulsed at pass 1, addr 7, then start K=1 with data 0xA5A50000+i -> outputs reset asynchronously; drain yields 0xA5A50000+i with no residue from the aborted job.
6. start pulsed again while busy, and start with K=0 from IDLE -> busy job unaffected; K=0 gives a done pulse next cycle, busy stays 0, no ram_wr_en.
